// File: rtl/hcsr04_pkg.sv
// Shared types and 50 MHz default timing constants for the HC-SR04 ranger.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } state_t;

    localparam int unsigned DEF_TRIG_CYC    = 500;
    localparam int unsigned DEF_CYC_PER_MM  = 291;
    localparam int unsigned DEF_TIMEOUT_CYC = 1900000;
    localparam int unsigned DEF_PERIOD_CYC  = 3000000;
    localparam int unsigned DEF_DIST_W      = 32;

    // Timeout marker; callers truncate to their distance width.
    function automatic logic [63:0] dist_timeout();
        return '1;
    endfunction

endpackage

// File: rtl/hcsr04_echo_sync.sv
// Two-flop synchronizer for the raw echo line plus rise/fall detection
// against a third delayed flop.
module hcsr04_echo_sync
    import hcsr04_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic echo_i,
    output logic echo_s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic dly;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            dly  <= 1'b0;
        end else begin
            meta <= echo_i;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign echo_s = sync;
    assign rise   = sync & ~dly;
    assign fall   = ~sync & dly;

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 driver: periodic trigger, echo width measured in mm with a
// prescaler and mm counter, timeout reported as an all-ones distance.
module hcsr04_ranger
    import hcsr04_pkg::*;
#(
    parameter int unsigned TRIG_CYC    = DEF_TRIG_CYC,
    parameter int unsigned CYC_PER_MM  = DEF_CYC_PER_MM,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int unsigned DIST_W      = DEF_DIST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              echo_i,
    output logic              trigger_o,
    output logic [DIST_W-1:0] distance_o,
    output logic              valid_o,
    output logic              timeout_o,
    output logic              busy_o
);

    localparam int unsigned PS_W = (CYC_PER_MM > 1) ? $clog2(CYC_PER_MM) : 1;

    state_t            state;
    logic [31:0]       trig_cnt;
    logic [31:0]       wait_cnt;
    logic [31:0]       period_cnt;
    logic [PS_W-1:0]   prescaler;
    logic [DIST_W-1:0] mm_cnt;

    logic echo_s;
    logic echo_rise;
    logic echo_fall;

    hcsr04_echo_sync u_echo_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .echo_i (echo_i),
        .echo_s (echo_s),
        .rise   (echo_rise),
        .fall   (echo_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            trig_cnt   <= '0;
            wait_cnt   <= '0;
            period_cnt <= '0;
            prescaler  <= '0;
            mm_cnt     <= '0;
            trigger_o  <= 1'b0;
            distance_o <= '0;
            valid_o    <= 1'b0;
            timeout_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;

            if (state != IDLE && period_cnt != '1)
                period_cnt <= period_cnt + 32'd1;

            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state      <= TRIG;
                        period_cnt <= '0;
                        trig_cnt   <= '0;
                        trigger_o  <= 1'b1;
                        busy_o     <= 1'b1;
                    end
                end

                TRIG: begin
                    if (trig_cnt == TRIG_CYC - 1) begin
                        state     <= WAIT_ECHO;
                        trigger_o <= 1'b0;
                        wait_cnt  <= '0;
                    end else begin
                        trig_cnt <= trig_cnt + 32'd1;
                    end
                end

                WAIT_ECHO: begin
                    if (echo_rise) begin
                        // The rise cycle is itself an echo-high sample, so it
                        // is counted here to keep distance = floor(N/CYC_PER_MM).
                        state     <= MEASURE;
                        wait_cnt  <= '0;
                        prescaler <= (CYC_PER_MM == 1) ? '0 : PS_W'(1);
                        mm_cnt    <= (CYC_PER_MM == 1) ? DIST_W'(1) : '0;
                    end else if (wait_cnt == TIMEOUT_CYC - 1) begin
                        state      <= HOLDOFF;
                        distance_o <= DIST_W'(dist_timeout());
                        valid_o    <= 1'b1;
                        timeout_o  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end

                MEASURE: begin
                    if (echo_fall) begin
                        state      <= HOLDOFF;
                        distance_o <= mm_cnt;
                        valid_o    <= 1'b1;
                    end else if (wait_cnt == TIMEOUT_CYC - 1) begin
                        state      <= HOLDOFF;
                        distance_o <= DIST_W'(dist_timeout());
                        valid_o    <= 1'b1;
                        timeout_o  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                        if (echo_s) begin
                            if (prescaler == PS_W'(CYC_PER_MM - 1)) begin
                                prescaler <= '0;
                                if (mm_cnt != '1)
                                    mm_cnt <= mm_cnt + DIST_W'(1);
                            end else begin
                                prescaler <= prescaler + PS_W'(1);
                            end
                        end
                    end
                end

                HOLDOFF: begin
                    // Already past the period (short PERIOD_CYC) exits at once.
                    if (period_cnt >= PERIOD_CYC - 1) begin
                        if (enable_i) begin
                            state      <= TRIG;
                            period_cnt <= '0;
                            trig_cnt   <= '0;
                            trigger_o  <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Scoreboard bench for hcsr04_ranger with small timing parameters.
module tb_hcsr04_ranger;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable_i = 1'b0;
    logic          echo_i = 1'b0;
    logic          trigger_o;
    logic [DW-1:0] distance_o;
    logic          valid_o;
    logic          timeout_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_valid_cyc = -1;
    int prev_rise = -1;
    logic [DW:0] exp_q[$];

    hcsr04_ranger #(
        .TRIG_CYC    (5),
        .CYC_PER_MM  (4),
        .TIMEOUT_CYC (200),
        .PERIOD_CYC  (600),
        .DIST_W      (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_i   (enable_i),
        .echo_i     (echo_i),
        .trigger_o  (trigger_o),
        .distance_o (distance_o),
        .valid_o    (valid_o),
        .timeout_o  (timeout_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid_o pulse must match the oldest expected result.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (valid_o === 1'b1) begin
            last_valid_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got dist=%0d timeout=%0b, required no valid", distance_o, timeout_o);
            end else begin
                e = exp_q.pop_front();
                if ({distance_o, timeout_o} !== e) begin
                    errors++;
                    $display("FAIL result: got dist=%0d timeout=%0b, required dist=%0d timeout=%0b",
                             distance_o, timeout_o, e[DW:1], e[0]);
                end
            end
        end
        if (timeout_o === 1'b1 && valid_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout_without_valid: got timeout_o=1 valid_o=%0b, required valid_o=1", valid_o);
        end
    end

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_trigger"}, trigger_o, 0);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_timeout"}, timeout_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_distance"}, distance_o, 0);
    endtask

    // Waits for the next trigger pulse, checks its width, returns at its fall.
    task automatic wait_trigger(input bit chk_period, output int fall_cyc);
        int n;
        int w;
        n = 0;
        while (trigger_o !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (trigger_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL trig_wait: got no trigger in 2000 cycles, required a trigger");
            fall_cyc = cyc;
            return;
        end
        if (chk_period && prev_rise >= 0)
            chk("trig_period", cyc - prev_rise, 600);
        prev_rise = cyc;
        chk("busy_in_trig", busy_o, 1);
        w = 0;
        while (trigger_o === 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("trig_width", w, 5);
        fall_cyc = cyc;
    endtask

    task automatic echo_pulse(input int n, output int fall_at);
        echo_i = 1'b1;
        repeat (n) @(negedge clk);
        echo_i = 1'b0;
        fall_at = cyc;
    endtask

    initial begin
        int f;
        int t;
        int r;
        int n;
        bit saw;

        rst_n = 1'b0;
        enable_i = 1'b1;
        echo_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // 40 high samples -> 10 mm, latency 3 cycles after echo fall
        wait_trigger(1'b0, f);
        repeat (10) @(negedge clk);
        exp_q.push_back({16'd10, 1'b0});
        echo_pulse(40, t);
        repeat (6) @(negedge clk);
        chk("valid_latency", last_valid_cyc - t, 3);

        // 43 -> 10 mm (truncation)
        wait_trigger(1'b1, f);
        repeat (10) @(negedge clk);
        exp_q.push_back({16'd10, 1'b0});
        echo_pulse(43, t);

        // 3 -> 0 mm, still reported
        wait_trigger(1'b1, f);
        repeat (10) @(negedge clk);
        exp_q.push_back({16'd0, 1'b0});
        echo_pulse(3, t);

        // No echo: timeout 200 cycles after trigger fall
        wait_trigger(1'b1, f);
        exp_q.push_back({16'hFFFF, 1'b1});
        repeat (210) @(negedge clk);
        chk("wait_timeout_latency", last_valid_cyc - f, 200);

        // Echo stuck high: MEASURE timeout, later fall gives nothing
        wait_trigger(1'b1, f);
        repeat (10) @(negedge clk);
        exp_q.push_back({16'hFFFF, 1'b1});
        t = cyc;
        echo_pulse(300, n);
        chk("measure_timeout_latency", last_valid_cyc - t, 203);
        repeat (10) @(negedge clk);

        // Drop enable mid-MEASURE: result still reported, then IDLE
        wait_trigger(1'b1, f);
        r = prev_rise;
        repeat (10) @(negedge clk);
        exp_q.push_back({16'd10, 1'b0});
        echo_i = 1'b1;
        repeat (20) @(negedge clk);
        enable_i = 1'b0;
        repeat (20) @(negedge clk);
        echo_i = 1'b0;
        while (cyc < r + 599) @(negedge clk);
        chk("busy_end_holdoff", busy_o, 1);
        @(negedge clk);
        chk("busy_after_holdoff", busy_o, 0);
        saw = 1'b0;
        repeat (700) begin
            @(negedge clk);
            if (trigger_o === 1'b1) saw = 1'b1;
        end
        chk("no_trigger_disabled", saw, 0);

        // Reset mid-MEASURE with echo held high through release
        enable_i = 1'b1;
        wait_trigger(1'b0, f);
        repeat (10) @(negedge clk);
        echo_i = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_trigger(1'b0, f);
        exp_q.push_back({16'hFFFF, 1'b1});
        repeat (210) @(negedge clk);
        chk("stale_echo_ignored", last_valid_cyc - f, 200);
        echo_i = 1'b0;

        // Fresh rise after the stale echo is measured normally
        wait_trigger(1'b1, f);
        repeat (10) @(negedge clk);
        exp_q.push_back({16'd5, 1'b0});
        echo_pulse(20, t);
        enable_i = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hcsr04_ranger.md
Name: hcsr04_ranger

Overview:
Drives the HC-SR04 ultrasonic sensor and converts each echo pulse into a distance in millimetres. It sits directly upstream of the slicer control core, which consumes distance_o/valid_o for feed positioning. The block owns the sensor's trigger/echo GPIO pair. Conversion uses only counters: a prescaler plus an mm counter, no divider.

Parameters:
TRIG_CYC, 500, trigger pulse width in clk cycles (10 us at 50 MHz)
CYC_PER_MM, 291, clk cycles of echo-high per mm of range (50e6*2/343000, truncated)
TIMEOUT_CYC, 1900000, max cycles in WAIT_ECHO or MEASURE (38 ms) before declaring timeout
PERIOD_CYC, 3000000, trigger-to-trigger period in cycles (60 ms)
DIST_W, 32, width of distance_o

Ports:
clk  in  1  system clock (CLOCK_50)
rst_n  in  1  reset; synchronous, active-low
enable_i  in  1  level; 1 = run periodic measurements
echo_i  in  1  raw sensor echo, asynchronous
trigger_o  out  1  sensor trigger pulse, registered
distance_o  out  DIST_W  last result in mm; holds between results
valid_o  out  1  one-cycle pulse, new distance_o available
timeout_o  out  1  one-cycle pulse coincident with valid_o when the result is a timeout
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, all counters 0, trigger_o=0, distance_o=0, valid_o=0, timeout_o=0, busy_o=0, sync flops 0. Applies from any state, including mid-MEASURE; no valid_o is produced for the aborted measurement.
- echo_i passes through a 2-FF synchronizer, giving echo_s. Rise and fall are detected against a third delayed flop. Only edges count; an echo already high on entry to WAIT_ECHO is ignored until it falls and rises again.
- States: IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
- IDLE: if enable_i, go to TRIG next edge and clear the period counter. The period counter counts every cycle from TRIG entry onward.
- TRIG: trigger_o high for exactly TRIG_CYC cycles, then WAIT_ECHO; wait counter cleared.
- WAIT_ECHO:
  - echo_s rise: go to MEASURE; clear the prescaler, mm counter and wait counter.
  - Wait counter reaches TIMEOUT_CYC-1: timeout result.
- MEASURE: each cycle echo_s is high, the prescaler increments.
  - Prescaler at CYC_PER_MM-1: wrap to 0, mm counter +1, saturating at all-ones.
  - echo_s fall: distance_o <= mm counter; valid_o=1 for one cycle; go to HOLDOFF.
  - Net result: distance_o = floor(N/CYC_PER_MM), where N = number of clk cycles echo_i was sampled high.
  - Wait counter reaches TIMEOUT_CYC-1 while echo_s is still high: timeout result.
- Timeout result: distance_o <= all-ones; valid_o=1 and timeout_o=1 for one cycle; go to HOLDOFF.
- Latency: valid_o is high in the cycle following the 3rd clk edge at which echo_i is sampled low.
- HOLDOFF: when the period counter reaches PERIOD_CYC-1, go to TRIG (period counter cleared) if enable_i, else IDLE. Consecutive trigger rising edges are therefore exactly PERIOD_CYC cycles apart.
- enable_i is sampled only in IDLE and at the end of HOLDOFF. Deasserting it mid-measurement lets the measurement complete and report.
- If PERIOD_CYC < TRIG_CYC+2*TIMEOUT_CYC, HOLDOFF exits immediately on entry (period counter already past PERIOD_CYC-1); the period stretches and no trigger overlap occurs.

Decomposition:
- Package hcsr04_pkg holds:
  - state_t enum {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF}
  - default constants for the 50 MHz clock
  - a DIST_TIMEOUT all-ones helper function
- One sub-module, hcsr04_echo_sync: 2-FF synchronizer plus edge detector. Outputs echo_s, rise, fall. Same clk/rst_n.

Test Plan:
Bench parameters: TRIG_CYC=5, CYC_PER_MM=4, TIMEOUT_CYC=200, PERIOD_CYC=600, DIST_W=16.
- Reset, then enable_i=1 -> outputs 0 during reset; trigger_o high for exactly 5 cycles; busy_o=1.
- Echo high 40 cycles after trigger -> distance_o=10, valid_o single-cycle pulse, timeout_o=0; repeat with 43 cycles -> distance_o=10; with 3 cycles -> distance_o=0, valid_o=1.
- No echo after trigger -> 200 cycles later distance_o=0xFFFF, valid_o=timeout_o=1 for one cycle, then HOLDOFF.
- Echo stuck high for 300 cycles -> timeout at MEASURE cycle 200, distance_o=0xFFFF; the later echo fall produces no extra valid_o.
- enable_i held high -> trigger_o rising edges exactly 600 cycles apart; drop enable_i during MEASURE -> that result is still reported, no further trigger_o, busy_o falls after HOLDOFF.
- rst_n low mid-MEASURE -> next edge all outputs 0, state IDLE, no valid_o; echo high at reset release is ignored until a fresh rise.
